// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Optional feature macro: BCD_BLANK_LEADING_EN (leading-zero blank flags).
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // True when DIGITS decimal digits can hold every IN_W-bit value.
  function automatic bit bcd_fits(input int unsigned digits, input int unsigned in_w);
    longint unsigned p10;
    longint unsigned max_in;
    p10 = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p10 = p10 * 64'd10;
    end
    max_in = (in_w >= 32'd64) ? '1 : ((64'd1 << in_w) - 64'd1);
    return p10 > max_in;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: nibble >= 5 gets 3 added (mod 16).
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nib,
  output logic [BCD_W-1:0] sum_c
);

  // Conditional add-3 ahead of the next left shift.
  always_comb begin
    sum_c = nib;
    if (nib >= ADD3_THRESH) begin
      sum_c = nib + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bcd_digit_converter.sv
// Sequential binary-to-BCD converter, one double-dabble shift per clock.
// The last result is held on digits while a new conversion runs.
// Optional feature macro: BCD_BLANK_LEADING_EN (registered leading-zero blank flags).
module bcd_digit_converter
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         in_value,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [BCD_W*DIGITS-1:0] digits,
  output logic                    out_valid,
  output logic [DIGITS-1:0]       digit_blank
);

  localparam int unsigned DIG_W = BCD_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  if (!bcd_fits(DIGITS, IN_W)) begin : g_bad_digits
    $error("bcd_digit_converter: DIGITS too small for IN_W");
  end

  state_e            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [DIG_W-1:0]  scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIG_W-1:0]  digits_q, digits_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [DIG_W-1:0]  adj;

  // One add-3 cell per scratch nibble.
  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .nib   (scratch_q[BCD_W*k +: BCD_W]),
      .sum_c (adj[BCD_W*k +: BCD_W])
    );
  end

  // State, shift registers, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      digits_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state logic: accept in IDLE, IN_W shifts, publish in DONE.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bin_d     = in_value;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_W - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        digits_d    = scratch_q;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  assign digits    = digits_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

`ifdef BCD_BLANK_LEADING_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_new;
  logic              upper_zero;

  // Blank digit k (k>0) when it and every more-significant digit are zero.
  always_comb begin
    blank_new  = '0;
    upper_zero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      upper_zero = upper_zero &&
                   (scratch_q[BCD_W*(int'(DIGITS)-1-i) +: BCD_W] == BCD_W'(0));
      if (i != int'(DIGITS) - 1) begin
        blank_new[int'(DIGITS)-1-i] = upper_zero;
      end
    end
    blank_d = (state_q == S_DONE) ? blank_new : blank_q;
  end

  // Blank flags update together with digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      blank_q <= blank_d;
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = '0;
`endif

endmodule
